// File: rtl/input_shift_register.sv
// Input shift register for one PIO state machine: gathers IN bits into a 32-bit word,
// tracks the fill count and pushes completed words into the RX FIFO, stalling on a full FIFO.
module input_shift_register (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        shift_en,
    input  logic [4:0]  shift_count,
    input  logic        shiftdir,
    input  logic        autopush,
    input  logic [4:0]  push_thresh,
    input  logic        push_req,
    input  logic        if_full,
    input  logic        block,
    input  logic [1:0]  mov,
    input  logic [31:0] mov_in,
    output logic [31:0] mov_out,
    input  logic        fifo_full,
    output logic        fifo_push,
    output logic [31:0] fifo_data,
    output logic        stall,
    output logic [5:0]  input_shift_counter
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] isr_r;
    logic [31:0] isr_nxt_s;
    logic [5:0]  cnt_r;
    logic [5:0]  cnt_nxt_s;

    logic [5:0]  n_s;
    logic [5:0]  thresh_s;
    logic [31:0] shifted_s;
    logic [6:0]  sum_s;
    logic [5:0]  cnt_shift_s;

    assign mov_out             = isr_r;
    assign input_shift_counter = cnt_r;

    // Decode shift amount and threshold (0 encodes 32), and precompute the shifted word and count.
    always_comb begin
        n_s         = (shift_count == 5'd0) ? 6'd32 : {1'b0, shift_count};
        thresh_s    = (push_thresh == 5'd0) ? 6'd32 : {1'b0, push_thresh};
        shifted_s   = 32'd0;
        if (n_s == 6'd32) begin
            shifted_s = data_in;
        end else if (shiftdir) begin
            shifted_s = (isr_r >> n_s) | (data_in << (6'd32 - n_s));
        end else begin
            shifted_s = (isr_r << n_s) | (data_in & ((32'd1 << n_s) - 32'd1));
        end
        sum_s       = {1'b0, cnt_r} + {1'b0, n_s};
        cnt_shift_s = (sum_s >= 7'd32) ? 6'd32 : sum_s[5:0];
    end

    // Command decode: next ISR/counter/state plus the same-cycle push strobe and stall.
    always_comb begin
        state_nxt_s = state_r;
        isr_nxt_s   = isr_r;
        cnt_nxt_s   = cnt_r;
        fifo_push   = 1'b0;
        fifo_data   = 32'd0;
        stall       = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (mov == 2'b01) begin
                    isr_nxt_s = mov_in;
                    cnt_nxt_s = 6'd0;
                end else if (mov == 2'b10) begin
                    isr_nxt_s = 32'd0;
                    cnt_nxt_s = 6'd0;
                end else if (push_req) begin
                    if (if_full && (cnt_r < thresh_s)) begin
                        isr_nxt_s = isr_r;
                    end else if (!fifo_full) begin
                        fifo_push = 1'b1;
                        fifo_data = isr_r;
                        isr_nxt_s = 32'd0;
                        cnt_nxt_s = 6'd0;
                    end else if (block) begin
                        stall       = 1'b1;
                        state_nxt_s = ST_STALL;
                    end else begin
                        isr_nxt_s = 32'd0;
                        cnt_nxt_s = 6'd0;
                    end
                end else if (shift_en) begin
                    if (autopush && (cnt_shift_s >= thresh_s)) begin
                        if (!fifo_full) begin
                            fifo_push = 1'b1;
                            fifo_data = shifted_s;
                            isr_nxt_s = 32'd0;
                            cnt_nxt_s = 6'd0;
                        end else begin
                            // The shift still commits; the shifted word waits in STALL.
                            isr_nxt_s   = shifted_s;
                            cnt_nxt_s   = cnt_shift_s;
                            stall       = 1'b1;
                            state_nxt_s = ST_STALL;
                        end
                    end else begin
                        isr_nxt_s = shifted_s;
                        cnt_nxt_s = cnt_shift_s;
                    end
                end else begin
                    isr_nxt_s = isr_r;
                end
            end
            ST_STALL: begin
                if (!fifo_full) begin
                    fifo_push   = 1'b1;
                    fifo_data   = isr_r;
                    isr_nxt_s   = 32'd0;
                    cnt_nxt_s   = 6'd0;
                    state_nxt_s = ST_RUN;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // State, shift register and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
            isr_r   <= 32'd0;
            cnt_r   <= 6'd0;
        end else begin
            state_r <= state_nxt_s;
            isr_r   <= isr_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

endmodule
